v2_deque_client_arbiter: RTL and testbench

//  Shares one v2 deque controller between p_nclients requesters.

---
 rtl/v2_deque_client_arbiter_pkg.sv | 37 +++
 rtl/v2_deque_client_arbiter_rr.sv | 44 ++++
 rtl/v2_deque_client_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_v2_deque_client_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/v2_deque_client_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// v2_deque_client_arbiter_pkg
//   Shared definitions for the deque client arbiter: controller op codes,
//   response status codes, arbiter FSM states and a small op-class helper.
// ----------------------------------------------------------------------------
package v2_deque_client_arbiter_pkg;

   // Controller op codes; all four 2-bit values are meaningful.
   typedef enum logic [1:0] {
      DQ_OP_ENQ_BACK  = 2'b00,
      DQ_OP_ENQ_FRONT = 2'b01,
      DQ_OP_DEQ_BACK  = 2'b10,
      DQ_OP_DEQ_FRONT = 2'b11
   } dq_op_e;

   // Response status returned to the client with every op.
   typedef enum logic [1:0] {
      DQ_ERR_NONE    = 2'd0,
      DQ_ERR_FULL    = 2'd1,
      DQ_ERR_EMPTY   = 2'd2,
      DQ_ERR_TIMEOUT = 2'd3
   } dq_err_e;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } dq_state_e;

   // True for the two enqueue op codes.
   function automatic logic op_is_enq(input dq_op_e op);
      return (op == DQ_OP_ENQ_BACK) || (op == DQ_OP_ENQ_FRONT);
   endfunction

endpackage

// File: rtl/v2_deque_client_arbiter_rr.sv
// ----------------------------------------------------------------------------
// v2_rr_arbiter
//   Combinational round-robin pick: the first requesting client at or after
//   rr_ptr, wrapping around.
//   req        in   [p_nclients]  request vector
//   rr_ptr     in   [p_idwidth]   highest-priority index
//   grant      out  [p_nclients]  one-hot grant (zero when nothing requests)
//   grant_idx  out  [p_idwidth]   index of the granted client
//   grant_val  out  1             some client is granted
// ----------------------------------------------------------------------------
module v2_rr_arbiter #(
   parameter int p_nclients = 4,
   parameter int p_idwidth  = $clog2(p_nclients)
) (
   input  logic [p_nclients-1:0] req,
   input  logic [p_idwidth-1:0]  rr_ptr,
   output logic [p_nclients-1:0] grant,
   output logic [p_idwidth-1:0]  grant_idx,
   output logic                  grant_val
);

   localparam logic [p_idwidth:0]    N_EXT   = (p_idwidth+1)'(p_nclients);
   localparam logic [p_nclients-1:0] ONE_LSB = p_nclients'(1);

   logic [p_idwidth:0]   sum_s;
   logic [p_idwidth-1:0] idx_s;

   // Scan offsets from the farthest to the nearest so the nearest requester
   // from rr_ptr is the last one written and therefore wins.
   always_comb begin
      sum_s     = '0;
      idx_s     = '0;
      grant_idx = '0;
      grant_val = 1'b0;
      for (int k = p_nclients - 1; k >= 0; k--) begin
         sum_s     = {1'b0, rr_ptr} + (p_idwidth+1)'(k);
         idx_s     = (sum_s >= N_EXT) ? p_idwidth'(sum_s - N_EXT) : p_idwidth'(sum_s);
         grant_idx = req[idx_s] ? idx_s : grant_idx;
         grant_val = grant_val | req[idx_s];
      end
      grant = grant_val ? (ONE_LSB << grant_idx) : '0;
   end

endmodule

// File: rtl/v2_deque_client_arbiter.sv
// ----------------------------------------------------------------------------
// v2_deque_client_arbiter
//   Shares one deque controller between p_nclients requesters. One op is in
//   flight at a time: grant -> single-cycle controller req -> wait for the
//   matching cpl (or time out) -> hold the response until the client takes it.
//   Occupancy is mirrored locally so full/empty ops are rejected without
//   touching the controller.
//   clk, rst                 clock, async active-high reset
//   cli_req_val/rdy/op/data  per-client op request (rdy is a one-hot grant)
//   cli_resp_val/rdy         per-client response handshake (val one-hot)
//   cli_resp_data/err        shared response payload and status
//   *_req / *_cpl            controller op strobes and completions
//   enq_data                 data for either enqueue op
//   deq_back/front_data      controller dequeue results
//   count                    mirrored occupancy
// ----------------------------------------------------------------------------
module v2_deque_client_arbiter
   import v2_deque_client_arbiter_pkg::*;
#(
   parameter int p_nclients = 4,
   parameter int p_depth    = 32,
   parameter int p_bitwidth = 32,
   parameter int p_timeout  = 8,
   parameter int p_idwidth  = $clog2(p_nclients)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [p_nclients-1:0]                 cli_req_val,
   output logic [p_nclients-1:0]                 cli_req_rdy,
   input  logic [p_nclients-1:0][1:0]            cli_req_op,
   input  logic [p_nclients-1:0][p_bitwidth-1:0] cli_req_data,
   output logic [p_nclients-1:0]                 cli_resp_val,
   input  logic [p_nclients-1:0]                 cli_resp_rdy,
   output logic [p_bitwidth-1:0]                 cli_resp_data,
   output logic [1:0]                            cli_resp_err,
   output logic                                  enq_back_req,
   output logic                                  enq_front_req,
   output logic                                  deq_back_req,
   output logic                                  deq_front_req,
   input  logic                                  enq_back_cpl,
   input  logic                                  enq_front_cpl,
   input  logic                                  deq_back_cpl,
   input  logic                                  deq_front_cpl,
   output logic [p_bitwidth-1:0]                 enq_data,
   input  logic [p_bitwidth-1:0]                 deq_back_data,
   input  logic [p_bitwidth-1:0]                 deq_front_data,
   output logic [$clog2(p_depth+1)-1:0]          count
);

   localparam int CW = $clog2(p_depth + 1);
   localparam int TW = $clog2(p_timeout);
   localparam logic [CW-1:0]         CNT_FULL = CW'(p_depth);
   localparam logic [TW-1:0]         TMR_LAST = TW'(p_timeout - 1);
   localparam logic [p_idwidth-1:0]  ID_LAST  = p_idwidth'(p_nclients - 1);
   localparam logic [p_nclients-1:0] ONE_LSB  = p_nclients'(1);

   dq_state_e                 state_q,     state_d;
   logic [p_idwidth-1:0]      rr_ptr_q,    rr_ptr_d;
   logic [p_idwidth-1:0]      id_q,        id_d;
   dq_op_e                    op_q,        op_d;
   logic [p_bitwidth-1:0]     data_q,      data_d;
   logic [CW-1:0]             count_q,     count_d;
   logic [TW-1:0]             timer_q,     timer_d;
   logic [3:0]                req_q,       req_d;
   logic [p_nclients-1:0]     resp_val_q,  resp_val_d;
   logic [p_bitwidth-1:0]     resp_data_q, resp_data_d;
   dq_err_e                   resp_err_q,  resp_err_d;

   logic [p_nclients-1:0]     grant_s;
   logic [p_idwidth-1:0]      grant_idx_s;
   logic                      grant_val_s;
   logic [3:0]                cpl_s;

   v2_rr_arbiter #(
      .p_nclients (p_nclients),
      .p_idwidth  (p_idwidth)
   ) u_rr (
      .req       (cli_req_val),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_val (grant_val_s)
   );

   // Completion and strobe vectors are both indexed by the op code.
   assign cpl_s         = {deq_front_cpl, deq_back_cpl, enq_front_cpl, enq_back_cpl};
   assign enq_back_req  = req_q[0];
   assign enq_front_req = req_q[1];
   assign deq_back_req  = req_q[2];
   assign deq_front_req = req_q[3];

   // Grant is only offered while idle; held low during reset as well.
   assign cli_req_rdy   = ((state_q == ST_IDLE) && !rst) ? grant_s : '0;
   assign cli_resp_val  = resp_val_q;
   assign cli_resp_data = resp_data_q;
   assign cli_resp_err  = resp_err_q;
   assign enq_data      = data_q;
   assign count         = count_q;

   // Next-state and next-output computation for the op sequencer.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      op_d        = op_q;
      data_d      = data_q;
      count_d     = count_q;
      timer_d     = timer_q;
      req_d       = 4'b0000;
      resp_val_d  = resp_val_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_val_s) begin
               id_d   = grant_idx_s;
               op_d   = dq_op_e'(cli_req_op[grant_idx_s]);
               data_d = cli_req_data[grant_idx_s];
               if (op_is_enq(op_d) && (count_q == CNT_FULL)) begin
                  state_d     = ST_RESP;
                  resp_val_d  = grant_s;
                  resp_data_d = '0;
                  resp_err_d  = DQ_ERR_FULL;
               end else if (!op_is_enq(op_d) && (count_q == '0)) begin
                  state_d     = ST_RESP;
                  resp_val_d  = grant_s;
                  resp_data_d = '0;
                  resp_err_d  = DQ_ERR_EMPTY;
               end else begin
                  // The strobe is registered, so it lives exactly in ISSUE.
                  state_d = ST_ISSUE;
                  req_d   = 4'b0001 << op_d;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            timer_d = '0;
         end
         ST_WAIT: begin
            if (cpl_s[op_q]) begin
               state_d    = ST_RESP;
               resp_val_d = ONE_LSB << id_q;
               resp_err_d = DQ_ERR_NONE;
               if (op_is_enq(op_q)) begin
                  resp_data_d = '0;
                  count_d     = (count_q != CNT_FULL) ? count_q + CW'(1) : count_q;
               end else begin
                  resp_data_d = (op_q == DQ_OP_DEQ_BACK) ? deq_back_data : deq_front_data;
                  count_d     = (count_q != '0) ? count_q - CW'(1) : count_q;
               end
            end else if (timer_q == TMR_LAST) begin
               // Op is considered lost; occupancy is left untouched.
               state_d     = ST_RESP;
               resp_val_d  = ONE_LSB << id_q;
               resp_data_d = '0;
               resp_err_d  = DQ_ERR_TIMEOUT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_RESP: begin
            if (cli_resp_rdy[id_q]) begin
               state_d     = ST_IDLE;
               resp_val_d  = '0;
               resp_data_d = '0;
               resp_err_d  = DQ_ERR_NONE;
               rr_ptr_d    = (id_q == ID_LAST) ? '0 : id_q + p_idwidth'(1);
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            resp_val_d = '0;
         end
      endcase
   end

   // State and registered-output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         op_q        <= DQ_OP_ENQ_BACK;
         data_q      <= '0;
         count_q     <= '0;
         timer_q     <= '0;
         req_q       <= 4'b0000;
         resp_val_q  <= '0;
         resp_data_q <= '0;
         resp_err_q  <= DQ_ERR_NONE;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         op_q        <= op_d;
         data_q      <= data_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         req_q       <= req_d;
         resp_val_q  <= resp_val_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

endmodule

// File: tb/tb_v2_deque_client_arbiter.sv
module tb_v2_deque_client_arbiter;

   localparam int NC = 4;
   localparam int DEPTH = 4;
   localparam int BW = 32;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [NC-1:0]         cli_req_val = '0;
   logic [NC-1:0]         cli_req_rdy;
   logic [NC-1:0][1:0]    cli_req_op = '0;
   logic [NC-1:0][BW-1:0] cli_req_data = '0;
   logic [NC-1:0]         cli_resp_val;
   logic [NC-1:0]         cli_resp_rdy = '1;
   logic [BW-1:0]         cli_resp_data;
   logic [1:0]            cli_resp_err;
   logic enq_back_req, enq_front_req, deq_back_req, deq_front_req;
   logic enq_back_cpl = 1'b0, enq_front_cpl = 1'b0, deq_back_cpl = 1'b0, deq_front_cpl = 1'b0;
   logic [BW-1:0] enq_data;
   logic [BW-1:0] deq_back_data = '0, deq_front_data = '0;
   logic [2:0]    count;
   logic          drop_cpl = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [BW-1:0] ctl_q[$];   // controller contents
   logic [BW-1:0] mq[$];      // reference model contents
   int grant_log[$];

   v2_deque_client_arbiter #(.p_nclients(NC), .p_depth(DEPTH), .p_bitwidth(BW), .p_timeout(TMO)) dut (
      .clk(clk), .rst(rst),
      .cli_req_val(cli_req_val), .cli_req_rdy(cli_req_rdy), .cli_req_op(cli_req_op), .cli_req_data(cli_req_data),
      .cli_resp_val(cli_resp_val), .cli_resp_rdy(cli_resp_rdy), .cli_resp_data(cli_resp_data), .cli_resp_err(cli_resp_err),
      .enq_back_req(enq_back_req), .enq_front_req(enq_front_req), .deq_back_req(deq_back_req), .deq_front_req(deq_front_req),
      .enq_back_cpl(enq_back_cpl), .enq_front_cpl(enq_front_cpl), .deq_back_cpl(deq_back_cpl), .deq_front_cpl(deq_front_cpl),
      .enq_data(enq_data), .deq_back_data(deq_back_data), .deq_front_data(deq_front_data), .count(count));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Behavioural deque controller: one-cycle completion, shares rst.
   // With drop_cpl set it silently loses the op.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q.delete();
         enq_back_cpl <= 1'b0; enq_front_cpl <= 1'b0; deq_back_cpl <= 1'b0; deq_front_cpl <= 1'b0;
      end else begin
         enq_back_cpl <= 1'b0; enq_front_cpl <= 1'b0; deq_back_cpl <= 1'b0; deq_front_cpl <= 1'b0;
         if (!drop_cpl) begin
            if (enq_back_req)  begin ctl_q.push_back(enq_data);  enq_back_cpl <= 1'b1; end
            if (enq_front_req) begin ctl_q.push_front(enq_data); enq_front_cpl <= 1'b1; end
            if (deq_back_req && ctl_q.size() > 0)  begin deq_back_data <= ctl_q.pop_back();   deq_back_cpl <= 1'b1; end
            if (deq_front_req && ctl_q.size() > 0) begin deq_front_data <= ctl_q.pop_front(); deq_front_cpl <= 1'b1; end
         end
      end
   end

   // Transaction-level reference: accept at c, req at c+1, resp at c+3
   // (c+2+TMO when lost), reject resp at c+1. Compared every cycle.
   initial begin : cmp_proc
      int cyc, m_id, m_op, req_cyc, resp_cyc, m_count, pend_count, mrr, g;
      bit busy;
      logic [BW-1:0] m_data, e_rdata;
      logic [1:0] e_err;
      logic [3:0] e_rdy, e_req, a_req, e_rval;
      cyc = 0; busy = 0; m_id = 0; m_op = 0; req_cyc = -1; resp_cyc = -1;
      m_count = 0; pend_count = 0; mrr = 0; m_data = '0; e_rdata = '0; e_err = 2'd0;
      forever begin
         @(negedge clk);
         cyc++;
         a_req = {deq_front_req, deq_back_req, enq_front_req, enq_back_req};
         if (rst) begin
            chk("rst_rdy", cli_req_rdy, 0);
            chk("rst_resp_val", cli_resp_val, 0);
            chk("rst_req", a_req, 0);
            chk("rst_count", count, 0);
            chk("rst_resp_data", cli_resp_data, 0);
            chk("rst_resp_err", cli_resp_err, 0);
            busy = 0; mrr = 0; m_count = 0; mq.delete();
         end else begin
            if (busy && cyc == req_cyc) begin
               e_rdata = '0; pend_count = m_count;
               if (drop_cpl) begin
                  resp_cyc = cyc + 1 + TMO; e_err = 2'd3;
               end else begin
                  resp_cyc = cyc + 2; e_err = 2'd0;
                  case (m_op)
                     0: begin mq.push_back(m_data);  pend_count++; end
                     1: begin mq.push_front(m_data); pend_count++; end
                     2: begin e_rdata = mq.pop_back();  pend_count--; end
                     default: begin e_rdata = mq.pop_front(); pend_count--; end
                  endcase
               end
            end
            if (busy && cyc == resp_cyc) m_count = pend_count;
            e_rdy = '0; g = -1;
            if (!busy) begin
               for (int k = 0; k < NC; k++)
                  if (g < 0 && cli_req_val[(mrr + k) % NC]) g = (mrr + k) % NC;
               if (g >= 0) e_rdy[g] = 1'b1;
            end
            e_req  = (busy && cyc == req_cyc) ? (4'b0001 << m_op) : 4'b0000;
            e_rval = (busy && cyc >= resp_cyc) ? (4'b0001 << m_id) : 4'b0000;
            chk("m_rdy", cli_req_rdy, e_rdy);
            chk("m_req", a_req, e_req);
            chk("m_resp_val", cli_resp_val, e_rval);
            chk("m_count", count, m_count);
            if (e_req != 0 && m_op < 2) chk("m_enq_data", enq_data, m_data);
            if (e_rval != 0) begin
               chk("m_resp_data", cli_resp_data, e_rdata);
               chk("m_resp_err", cli_resp_err, e_err);
            end
            if (!busy && g >= 0) begin
               busy = 1; m_id = g; m_op = int'(cli_req_op[g]); m_data = cli_req_data[g];
               grant_log.push_back(g);
               e_rdata = '0; pend_count = m_count;
               if (m_op < 2 && m_count == DEPTH) begin
                  req_cyc = -1; resp_cyc = cyc + 1; e_err = 2'd1;
               end else if (m_op >= 2 && m_count == 0) begin
                  req_cyc = -1; resp_cyc = cyc + 1; e_err = 2'd2;
               end else begin
                  req_cyc = cyc + 1; resp_cyc = 32'h7fffffff;
               end
            end else if (busy && cyc >= resp_cyc && cli_resp_rdy[m_id]) begin
               busy = 0; mrr = (m_id + 1) % NC;
            end
         end
      end
   end

   task automatic do_op(input int c, input logic [1:0] op, input logic [BW-1:0] d,
                        output logic [BW-1:0] rd, output logic [1:0] re, output int lat, output int pulses);
      bit seen;
      rd = '0; re = 2'd0; lat = 0; pulses = 0; seen = 0;
      cli_req_op[c] = op; cli_req_data[c] = d; cli_req_val[c] = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = cli_req_rdy[c]; end
      chk("grant_wait", seen, 1);
      @(posedge clk); #1; cli_req_val[c] = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         pulses += int'(enq_back_req) + int'(enq_front_req) + int'(deq_back_req) + int'(deq_front_req);
         if (cli_resp_val[c]) begin seen = 1; lat = i + 1; rd = cli_resp_data; re = cli_resp_err; end
      end
      chk("resp_wait", seen, 1);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
   endtask

   task automatic rand_phase(input int ncyc, input bit allow_new);
      bit waiting[NC];
      bit hs_req[NC], hs_resp[NC];
      for (int c = 0; c < NC; c++) waiting[c] = 0;
      repeat (ncyc) begin
         @(negedge clk);
         for (int c = 0; c < NC; c++) begin
            hs_req[c]  = cli_req_val[c] & cli_req_rdy[c];
            hs_resp[c] = cli_resp_val[c] & cli_resp_rdy[c];
         end
         @(posedge clk); #1;
         for (int c = 0; c < NC; c++) begin
            if (hs_req[c]) begin cli_req_val[c] = 1'b0; waiting[c] = 1; end
            if (hs_resp[c]) waiting[c] = 0;
            if (allow_new && !cli_req_val[c] && !waiting[c] && $urandom_range(0, 3) == 0) begin
               cli_req_val[c] = 1'b1;
               cli_req_op[c] = 2'($urandom_range(0, 3));
               cli_req_data[c] = $urandom;
            end
            cli_resp_rdy[c] = allow_new ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         drop_cpl = allow_new ? ($urandom_range(0, 15) == 0) : 1'b0;
      end
   endtask

   initial begin : stim
      logic [BW-1:0] rd;
      logic [1:0] re;
      int lat, pulses;
      bit seen;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", count, 0);
      chk("reset_resp_val", cli_resp_val, 0);
      rst = 1'b0;

      // Deq on empty -> local EMPTY reject.
      do_op(0, 2'b11, 32'h0, rd, re, lat, pulses);
      chk("empty_err", re, 2'd2); chk("empty_data", rd, 0);
      chk("empty_lat", lat, 1); chk("empty_noreq", pulses, 0); chk("empty_count", count, 0);

      // Enq then deq through a different client.
      do_op(0, 2'b00, 32'hA, rd, re, lat, pulses);
      chk("t1_enq_err", re, 2'd0); chk("t1_enq_lat", lat, 3); chk("t1_req_pulse", pulses, 1);
      chk("t1_count1", count, 1);
      do_op(1, 2'b11, 32'h0, rd, re, lat, pulses);
      chk("t1_deq_data", rd, 32'hA); chk("t1_deq_err", re, 2'd0); chk("t1_count0", count, 0);

      // Fill, overflow, drain.
      for (int i = 1; i <= 4; i++) do_op(2, 2'b00, 32'(i), rd, re, lat, pulses);
      chk("t3_count4", count, 4);
      do_op(2, 2'b01, 32'h5, rd, re, lat, pulses);
      chk("t3_full_err", re, 2'd1); chk("t3_full_lat", lat, 1); chk("t3_full_noreq", pulses, 0);
      for (int i = 4; i >= 1; i--) begin
         do_op(3, 2'b10, 32'h0, rd, re, lat, pulses);
         chk("t3_deq_back", rd, 32'(i));
      end

      // Lost completion -> TIMEOUT, then normal service resumes.
      drop_cpl = 1'b1;
      do_op(3, 2'b00, 32'h55, rd, re, lat, pulses);
      drop_cpl = 1'b0;
      chk("t5_err", re, 2'd3); chk("t5_lat", lat, 2 + TMO); chk("t5_count", count, 0);
      do_op(0, 2'b00, 32'h66, rd, re, lat, pulses);
      do_op(1, 2'b10, 32'h0, rd, re, lat, pulses);
      chk("t5_after_data", rd, 32'h66);

      // All clients valid continuously from reset: grants 0,1,2,3,0.
      do_reset();
      grant_log.delete();
      for (int c = 0; c < NC; c++) begin cli_req_op[c] = 2'b00; cli_req_data[c] = 32'(c + 16); end
      cli_req_val = '1;
      for (int i = 0; i < 100 && grant_log.size() < 5; i++) @(posedge clk);
      #1; cli_req_val = '0;
      repeat (6) @(posedge clk);
      #1;
      chk("t2_ngrants", grant_log.size() >= 5, 1);
      if (grant_log.size() >= 5) begin
         chk("t2_g0", grant_log[0], 0); chk("t2_g1", grant_log[1], 1);
         chk("t2_g2", grant_log[2], 2); chk("t2_g3", grant_log[3], 3);
         chk("t2_g4", grant_log[4], 0);
      end

      // Async reset while waiting for a completion.
      do_reset();
      cli_req_op[1] = 2'b00; cli_req_data[1] = 32'h99; cli_req_val[1] = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = cli_req_rdy[1]; end
      @(posedge clk); #1; cli_req_val[1] = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = enq_back_req; end
      chk("t6_req_seen", seen, 1);
      @(negedge clk); #2; rst = 1'b1; #1;
      chk("t6_resp_val", cli_resp_val, 0);
      chk("t6_count", count, 0);
      chk("t6_req", {deq_front_req, deq_back_req, enq_front_req, enq_back_req}, 0);
      chk("t6_resp_data", cli_resp_data, 0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      do_op(2, 2'b00, 32'h77, rd, re, lat, pulses);
      do_op(3, 2'b11, 32'h0, rd, re, lat, pulses);
      chk("t6_after_data", rd, 32'h77); chk("t6_after_err", re, 2'd0);

      // Randomized traffic, then drain.
      rand_phase(1500, 1'b1);
      rand_phase(80, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
